// File: rtl/bounded_step_counter_if.sv
// rtl/bounded_step_counter_if.sv - control/status bundle for bounded_step_counter (wrap_count present when COUNTER_WRAP_CNT_EN is defined)
interface bounded_step_counter_if #(
  parameter int COUNTER_WIDTH = 8,
  parameter int STEP_WIDTH    = 4
);
  logic                     start;
  logic                     stop;
  logic                     enable;
  logic                     load;
  logic [COUNTER_WIDTH-1:0] load_value;
  logic                     up_down;
  logic [1:0]               mode;
  logic [COUNTER_WIDTH-1:0] min_count;
  logic [COUNTER_WIDTH-1:0] max_count;
  logic [STEP_WIDTH-1:0]    step;
  logic [COUNTER_WIDTH-1:0] count_out;
  logic                     dir_out;
  logic                     busy;
  logic                     at_bound;
  logic                     done;
  logic                     cfg_err;
`ifdef COUNTER_WRAP_CNT_EN
  logic [15:0]              wrap_count;
`endif

  modport master (
    output start, stop, enable, load, load_value, up_down, mode,
           min_count, max_count, step,
`ifdef COUNTER_WRAP_CNT_EN
    input  wrap_count,
`endif
    input  count_out, dir_out, busy, at_bound, done, cfg_err
  );

  modport slave (
    input  start, stop, enable, load, load_value, up_down, mode,
           min_count, max_count, step,
`ifdef COUNTER_WRAP_CNT_EN
    output wrap_count,
`endif
    output count_out, dir_out, busy, at_bound, done, cfg_err
  );
endinterface

// File: rtl/bounded_step_counter.sv
// rtl/bounded_step_counter.sv - bounded up/down step counter with wrap/saturate/one-shot/bounce modes; optional wrap_count via COUNTER_WRAP_CNT_EN
module bounded_step_counter #(
  parameter int COUNTER_WIDTH = 8,
  parameter int STEP_WIDTH    = 4
) (
  input logic                    clk_i,
  input logic                    reset_i,
  bounded_step_counter_if.slave  bus
);

  localparam int CW = COUNTER_WIDTH;

  localparam logic [1:0] MODE_WRAP    = 2'd0;
  localparam logic [1:0] MODE_SAT     = 2'd1;
  localparam logic [1:0] MODE_ONESHOT = 2'd2;
  localparam logic [1:0] MODE_BOUNCE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          dir_q, dir_d;
  logic          done_q, done_d;

  logic          cfg_err;
  logic [CW-1:0] term_bound;
  logic [CW-1:0] far_bound;
  logic          at_term;
  logic          step_ok;
  logic          start_go;
  logic          term_evt;
  logic [CW:0]   step_ext;

  assign cfg_err    = bus.min_count > bus.max_count;
  assign term_bound = dir_q ? bus.max_count : bus.min_count;
  assign far_bound  = dir_q ? bus.min_count : bus.max_count;
  assign at_term    = (count_q == term_bound);
  assign step_ext   = {{(CW + 1 - STEP_WIDTH){1'b0}}, bus.step};
  assign step_ok    = (state_q == ST_RUN) && bus.enable && !cfg_err && (bus.step != '0);
  assign start_go   = !bus.load && !bus.stop && bus.start;

  // One step toward bound in CW+1 bits; reaching or passing the bound lands exactly on it,
  // so the count never crosses the numeric 0 / 2^CW boundary.
  function automatic logic [CW-1:0] move_clamped(input logic [CW-1:0] cur,
                                                 input logic          up,
                                                 input logic [CW-1:0] bound,
                                                 input logic [CW:0]   stp);
    logic [CW:0] cur_x;
    logic [CW:0] bnd_x;
    logic [CW:0] nxt_x;
    cur_x = {1'b0, cur};
    bnd_x = {1'b0, bound};
    if (up) begin
      nxt_x = cur_x + stp;
      if (nxt_x >= bnd_x) nxt_x = bnd_x;
    end else begin
      if (cur_x <= bnd_x + stp) nxt_x = bnd_x;
      else                      nxt_x = cur_x - stp;
    end
    return nxt_x[CW-1:0];
  endfunction

  // State register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic: load freezes the state, then stop, start, one-shot terminal event
  always_comb begin
    state_d = state_q;
    if (bus.load) begin
      state_d = state_q;
    end else if (bus.stop) begin
      state_d = ST_IDLE;
    end else if (bus.start) begin
      state_d = ST_RUN;
    end else if (term_evt && (bus.mode == MODE_ONESHOT)) begin
      state_d = ST_HALT;
    end
  end

  // Outputs derived from state and datapath registers
  always_comb begin
    bus.busy      = (state_q == ST_RUN);
    bus.count_out = count_q;
    bus.dir_out   = dir_q;
    bus.done      = done_q;
    bus.at_bound  = at_term;
    bus.cfg_err   = cfg_err;
  end

  // Datapath next values: count, direction and terminal-event detection
  always_comb begin
    count_d  = count_q;
    dir_d    = dir_q;
    term_evt = 1'b0;
    if (bus.load) begin
      count_d = bus.load_value;
    end else if (bus.stop) begin
      count_d = count_q;
    end else if (bus.start) begin
      dir_d   = bus.up_down;
      count_d = bus.up_down ? bus.min_count : bus.max_count;
    end else if (step_ok) begin
      if (at_term) begin
        // End-of-range: one-shot cannot normally get here; it simply holds like saturate
        case (bus.mode)
          MODE_WRAP:   count_d = far_bound;
          MODE_BOUNCE: begin
            dir_d   = ~dir_q;
            count_d = move_clamped(count_q, ~dir_q, far_bound, step_ext);
          end
          default:     count_d = count_q;
        endcase
      end else begin
        count_d  = move_clamped(count_q, dir_q, term_bound, step_ext);
        term_evt = (count_d == term_bound);
      end
    end
  end

  assign done_d = term_evt;

  // Datapath registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
      dir_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

`ifdef COUNTER_WRAP_CNT_EN
  logic [15:0] wrap_cnt_q, wrap_cnt_d;
  logic        lap_evt;

  assign lap_evt = !bus.load && !bus.stop && !bus.start && step_ok && at_term &&
                   ((bus.mode == MODE_WRAP) || (bus.mode == MODE_BOUNCE));

  // Lap counter: terminal events plus wrap/bounce end-of-range steps, saturating
  always_comb begin
    wrap_cnt_d = wrap_cnt_q;
    if (start_go) begin
      wrap_cnt_d = '0;
    end else if ((term_evt || lap_evt) && (wrap_cnt_q != 16'hFFFF)) begin
      wrap_cnt_d = wrap_cnt_q + 16'd1;
    end
  end

  // Lap counter register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) wrap_cnt_q <= '0;
    else         wrap_cnt_q <= wrap_cnt_d;
  end

  assign bus.wrap_count = wrap_cnt_q;
`else
  logic unused_start_go;
  assign unused_start_go = start_go;
`endif

endmodule

// File: tb/tb_bounded_step_counter.sv
// tb/tb_bounded_step_counter.sv - randomized and directed self-checking bench for bounded_step_counter
module tb_bounded_step_counter;

  logic clk;
  logic reset;

  bounded_step_counter_if #(.COUNTER_WIDTH(8), .STEP_WIDTH(4)) bus ();

  bounded_step_counter #(.COUNTER_WIDTH(8), .STEP_WIDTH(4)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  // reference model: state 0=idle 1=run 2=halt
  int m_cnt;
  int m_dir;
  int m_st;
  int m_done;
  int m_wc;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_dir = 1; m_st = 0; m_done = 0; m_wc = 0;
  endtask

  // Applies the rules for one clock edge using plain integer arithmetic
  task automatic model_edge();
    int mn, mx, t, f, nxt, ev, lap, stp;
    mn = int'(bus.min_count);
    mx = int'(bus.max_count);
    stp = int'(bus.step);
    ev = 0;
    lap = 0;
    if (bus.load) begin
      m_cnt = int'(bus.load_value);
    end else if (bus.stop) begin
      m_st = 0;
    end else if (bus.start) begin
      m_st = 1;
      m_dir = int'(bus.up_down);
      m_cnt = bus.up_down ? mn : mx;
      m_wc = 0;
    end else if (m_st == 1 && bus.enable && mn <= mx && stp != 0) begin
      t = m_dir ? mx : mn;
      f = m_dir ? mn : mx;
      if (m_cnt == t) begin
        if (bus.mode == 2'd0) begin
          m_cnt = f; lap = 1;
        end else if (bus.mode == 2'd3) begin
          m_dir = 1 - m_dir;
          nxt = m_dir ? m_cnt + stp : m_cnt - stp;
          if (m_dir ? nxt >= f : nxt <= f) nxt = f;
          m_cnt = nxt; lap = 1;
        end
      end else begin
        nxt = m_dir ? m_cnt + stp : m_cnt - stp;
        if (m_dir ? nxt >= t : nxt <= t) nxt = t;
        m_cnt = nxt;
        if (nxt == t) begin
          ev = 1;
          if (bus.mode == 2'd2) m_st = 2;
        end
      end
    end
    m_done = ev;
    if ((ev || lap) && m_wc < 65535) m_wc++;
  endtask

  task automatic compare_all();
    int tb;
    tb = m_dir ? int'(bus.max_count) : int'(bus.min_count);
    check("count", int'(bus.count_out), m_cnt);
    check("dir", int'(bus.dir_out), m_dir);
    check("busy", int'(bus.busy), (m_st == 1) ? 1 : 0);
    check("done", int'(bus.done), m_done);
    check("at_bound", int'(bus.at_bound), (m_cnt == tb) ? 1 : 0);
    check("cfg_err", int'(bus.cfg_err), (bus.min_count > bus.max_count) ? 1 : 0);
`ifdef COUNTER_WRAP_CNT_EN
    check("wrap_count", int'(bus.wrap_count), m_wc);
`endif
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // Runs a sequence whose first edge carries start; checks against literal expectations
  task automatic expect_seq(input string tag, input int ec[$], input int ed[$]);
    for (int i = 0; i < ec.size(); i++) begin
      tick();
      bus.start = 1'b0;
      check({tag, "_count"}, int'(bus.count_out), ec[i]);
      check({tag, "_done"}, int'(bus.done), ed[i]);
    end
  endtask

  task automatic set_cfg(input int md, input int ud, input int mn, input int mx, input int st);
    bus.mode      = 2'(md);
    bus.up_down   = 1'(ud);
    bus.min_count = 8'(mn);
    bus.max_count = 8'(mx);
    bus.step      = 4'(st);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    bus.start = 0; bus.stop = 0; bus.enable = 0; bus.load = 0; bus.load_value = '0;
    set_cfg(0, 1, 0, 0, 0);
    model_reset();

    reset = 1'b1;
    #1;
    check("rst_count", int'(bus.count_out), 0);
    check("rst_dir", int'(bus.dir_out), 1);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;

    // wrap, up, 2..10 step 3
    set_cfg(0, 1, 2, 10, 3);
    bus.enable = 1'b1;
    bus.start  = 1'b1;
    expect_seq("wrap", '{2, 5, 8, 10, 2, 5}, '{0, 0, 0, 1, 0, 0});

    // saturate, down, 0..9 step 4
    set_cfg(1, 0, 0, 9, 4);
    bus.start = 1'b1;
    expect_seq("sat", '{9, 5, 1, 0, 0, 0}, '{0, 0, 0, 1, 0, 0});

    // one-shot, up, 0..5 step 2
    set_cfg(2, 1, 0, 5, 2);
    bus.start = 1'b1;
    expect_seq("oneshot", '{0, 2, 4, 5, 5}, '{0, 0, 0, 1, 0});
    check("oneshot_halt_busy", int'(bus.busy), 0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("oneshot_restart_count", int'(bus.count_out), 0);
    check("oneshot_restart_busy", int'(bus.busy), 1);

    // bounce, 1..4 step 1
    set_cfg(3, 1, 1, 4, 1);
    bus.start = 1'b1;
    expect_seq("bounce", '{1, 2, 3, 4, 3, 2, 1, 2}, '{0, 0, 0, 1, 0, 0, 1, 0});
    check("bounce_dir", int'(bus.dir_out), 1);

    // load beats start on the same edge
    bus.load = 1'b1; bus.load_value = 8'd7; bus.start = 1'b1;
    tick();
    bus.load = 1'b0; bus.start = 1'b0;
    check("load_count", int'(bus.count_out), 7);
    check("load_busy", int'(bus.busy), 1);

    // inverted bounds freeze the count
    set_cfg(3, 1, 9, 3, 1);
    for (int i = 0; i < 3; i++) tick();
    check("cfgerr_flag", int'(bus.cfg_err), 1);
    check("cfgerr_count", int'(bus.count_out), 7);

    // asynchronous reset mid-run at count 6
    set_cfg(0, 1, 0, 20, 2);
    bus.start = 1'b1;
    expect_seq("pre_rst", '{0, 2, 4, 6}, '{0, 0, 0, 0});
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("async_rst_count", int'(bus.count_out), 0);
    check("async_rst_busy", int'(bus.busy), 0);
    check("async_rst_done", int'(bus.done), 0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      bus.load       = ($urandom_range(0, 19) == 0);
      bus.load_value = 8'($urandom_range(0, 255));
      bus.stop       = ($urandom_range(0, 39) == 0);
      bus.start      = ($urandom_range(0, 14) == 0);
      bus.enable     = ($urandom_range(0, 3) != 0);
      bus.up_down    = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) bus.step = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 29) == 0) bus.mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) begin
        int mn, mx;
        mn = $urandom_range(0, 200);
        mx = mn + $urandom_range(0, 55);
        case ($urandom_range(0, 7))
          0: mn = 0;
          1: mx = 255;
          2: mx = mn;
          3: begin int tmp; tmp = mn; mn = mx; mx = tmp; end
          default: ;
        endcase
        bus.min_count = 8'(mn);
        bus.max_count = 8'(mx);
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
